// File: rtl/syslatch_pkg.sv
// syslatch_pkg
// Shared definitions for the system-latch write sequencer:
//   - state_t      : sequencer states (init walk + normal write path)
//   - REG_*        : 4-bit latch codes {data, bit[2:0]} as seen on LATCH_ADDR
//   - BIT_*        : latch bit indices inside SLATCH_MIRROR
//   - latch_code() : builds a latch code from a data value and bit index
//   - is_init()    : true for the three init-walk states
package syslatch_pkg;

  typedef enum logic [2:0] {
    ST_INIT_SETUP  = 3'd0,
    ST_INIT_STROBE = 3'd1,
    ST_INIT_HOLD   = 3'd2,
    ST_IDLE        = 3'd3,
    ST_SETUP       = 3'd4,
    ST_STROBE      = 3'd5,
    ST_HOLD        = 3'd6
  } state_t;

  // Latch codes: bit 3 is the value written, bits 2:0 select the latch bit.
  localparam logic [3:0] REG_NOSHADOW   = 4'h0;
  localparam logic [3:0] REG_SWPBIOS    = 4'h1;
  localparam logic [3:0] REG_CRDUNLOCK1 = 4'h2;
  localparam logic [3:0] REG_CRDLOCK2   = 4'h3;
  localparam logic [3:0] REG_CRDREGSEL  = 4'h4;
  localparam logic [3:0] REG_BRDFIX     = 4'h5;
  localparam logic [3:0] REG_SRAMLOCK   = 4'h6;
  localparam logic [3:0] REG_PALBANK1   = 4'h7;
  localparam logic [3:0] REG_SHADOW     = 4'h8;
  localparam logic [3:0] REG_SWPROM     = 4'h9;
  localparam logic [3:0] REG_CRDLOCK1   = 4'hA;
  localparam logic [3:0] REG_CRDUNLOCK2 = 4'hB;
  localparam logic [3:0] REG_CRDNORMAL  = 4'hC;
  localparam logic [3:0] REG_CRTFIX     = 4'hD;
  localparam logic [3:0] REG_SRAMUNLOCK = 4'hE;
  localparam logic [3:0] REG_PALBANK0   = 4'hF;

  // Latch bit positions within the mirror.
  localparam int BIT_SHADOW   = 0;
  localparam int BIT_NVEC     = 1;
  localparam int BIT_NCARDWEN = 2;
  localparam int BIT_CARDWENB = 3;
  localparam int BIT_NREGEN   = 4;
  localparam int BIT_NSYSTEM  = 5;
  localparam int BIT_SRAMWEN  = 6;
  localparam int BIT_PALBNK   = 7;

  function automatic logic [3:0] latch_code(input logic value, input logic [2:0] idx);
    return {value, idx};
  endfunction

  function automatic logic is_init(input state_t s);
    return (s == ST_INIT_SETUP) || (s == ST_INIT_STROBE) || (s == ST_INIT_HOLD);
  endfunction

endpackage

// File: rtl/syslatch_req_slot.sv
// syslatch_req_slot
// Decodes 68K writes into the latch window, turns each bus cycle into a single
// one-cycle request, and buffers one request while the sequencer is busy.
// Ports:
//   CLK, nRESET            : clock, synchronous active-low reset
//   M68K_ADDR[23:1]        : 68K address bus
//   M68K_RW, nAS, nLDS     : 68K bus controls
//   busy                   : sequencer is not idle
//   take                   : sequencer consumes the pending slot this cycle
//   req, req_addr          : registered request pulse and its latch code
//   slot_full, slot_addr   : pending slot state
//   overrun                : one-cycle pulse when a request is dropped
module syslatch_req_slot #(
  parameter logic [23:0] BASE_ADDR = 24'h3A0000
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic [23:1] M68K_ADDR,
  input  logic        M68K_RW,
  input  logic        nAS,
  input  logic        nLDS,
  input  logic        busy,
  input  logic        take,
  output logic        req,
  output logic [3:0]  req_addr,
  output logic        slot_full,
  output logic [3:0]  slot_addr,
  output logic        overrun
);

  logic hit;
  logic hit_q;

  assign hit = !nAS && !M68K_RW && !nLDS && (M68K_ADDR[23:5] == BASE_ADDR[23:5]);

  // A request is the rising edge of the registered hit, so a bus cycle held
  // for many clocks produces exactly one write.
  // When the slot is consumed, a coincident request takes its place; a
  // request arriving while busy with the slot already full is dropped.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      hit_q     <= 1'b0;
      req       <= 1'b0;
      req_addr  <= 4'h0;
      slot_full <= 1'b0;
      slot_addr <= 4'h0;
      overrun   <= 1'b0;
    end else begin
      hit_q   <= hit;
      req     <= hit && !hit_q;
      overrun <= req && busy && slot_full;
      if (hit && !hit_q) begin
        req_addr <= M68K_ADDR[4:1];
      end
      if (take) begin
        slot_full <= req;
        if (req) begin
          slot_addr <= req_addr;
        end
      end else if (req && busy && !slot_full) begin
        slot_full <= 1'b1;
        slot_addr <= req_addr;
      end
    end
  end

endmodule

// File: rtl/syslatch_seq.sv
// syslatch_seq
// Generates setup/strobe/hold write cycles (nBITW1) for the addressable system
// latch from 68K writes, after first walking all 8 latch bits to INIT_VALUE.
// Ports:
//   CLK, nRESET            : clock, synchronous active-low reset
//   M68K_ADDR[23:1]        : 68K address bus
//   M68K_RW, nAS, nLDS     : 68K bus controls
//   LATCH_ADDR[3:0]        : {data, bit select} to the latch
//   nBITW1                 : latch write strobe, active low
//   nWAIT                  : low while the pending slot is full or init runs
//   BUSY                   : high whenever the sequencer is not idle
//   OVERRUN                : one-cycle pulse when a request is dropped
//   SLATCH_MIRROR[7:0]     : registered copy of the latch contents
module syslatch_seq
  import syslatch_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR     = 24'h3A0000,
  parameter logic [7:0]  INIT_VALUE    = 8'h00,
  parameter int          STROBE_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic [23:1] M68K_ADDR,
  input  logic        M68K_RW,
  input  logic        nAS,
  input  logic        nLDS,
  output logic [3:0]  LATCH_ADDR,
  output logic        nBITW1,
  output logic        nWAIT,
  output logic        BUSY,
  output logic        OVERRUN,
  output logic [7:0]  SLATCH_MIRROR
);

  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

  state_t     state;
  logic [2:0] idx;
  logic [2:0] next_idx;
  logic [3:0] cnt;
  logic [3:0] latch_addr;
  logic       nbitw1;
  logic [7:0] mirror;

  logic       req;
  logic [3:0] req_addr;
  logic       slot_full;
  logic [3:0] slot_addr;
  logic       overrun;
  logic       busy;
  logic       take;

  assign busy     = (state != ST_IDLE);
  assign take     = (state == ST_IDLE) && slot_full;
  assign next_idx = idx + 3'd1;

  syslatch_req_slot #(
    .BASE_ADDR (BASE_ADDR)
  ) u_req_slot (
    .CLK       (CLK),
    .nRESET    (nRESET),
    .M68K_ADDR (M68K_ADDR),
    .M68K_RW   (M68K_RW),
    .nAS       (nAS),
    .nLDS      (nLDS),
    .busy      (busy),
    .take      (take),
    .req       (req),
    .req_addr  (req_addr),
    .slot_full (slot_full),
    .slot_addr (slot_addr),
    .overrun   (overrun)
  );

  // Sequencer. LATCH_ADDR is loaded before the strobe falls so it is stable
  // for the whole setup/strobe/hold window. During the init walk the next
  // code is preloaded from INIT_HOLD; INIT_SETUP also loads it so the first
  // bit after reset (when LATCH_ADDR was forced to 0) gets the right code.
  // The mirror is only written from HOLD, so a write cut short by reset is
  // never reflected there.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      state      <= ST_INIT_SETUP;
      idx        <= 3'd0;
      cnt        <= 4'd0;
      latch_addr <= 4'h0;
      nbitw1     <= 1'b1;
      mirror     <= 8'h00;
    end else begin
      case (state)
        ST_INIT_SETUP: begin
          latch_addr <= latch_code(INIT_VALUE[idx], idx);
          nbitw1     <= 1'b0;
          cnt        <= STROBE_LAST;
          state      <= ST_INIT_STROBE;
        end
        ST_INIT_STROBE: begin
          if (cnt == 4'd0) begin
            nbitw1 <= 1'b1;
            state  <= ST_INIT_HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_INIT_HOLD: begin
          mirror[idx] <= INIT_VALUE[idx];
          if (idx == 3'd7) begin
            state <= ST_IDLE;
          end else begin
            idx        <= next_idx;
            latch_addr <= latch_code(INIT_VALUE[next_idx], next_idx);
            state      <= ST_INIT_SETUP;
          end
        end
        ST_IDLE: begin
          if (slot_full) begin
            latch_addr <= slot_addr;
            state      <= ST_SETUP;
          end else if (req) begin
            latch_addr <= req_addr;
            state      <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          nbitw1 <= 1'b0;
          cnt    <= STROBE_LAST;
          state  <= ST_STROBE;
        end
        ST_STROBE: begin
          if (cnt == 4'd0) begin
            nbitw1 <= 1'b1;
            state  <= ST_HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_HOLD: begin
          mirror[latch_addr[2:0]] <= latch_addr[3];
          state                   <= ST_IDLE;
        end
        default: begin
          nbitw1 <= 1'b1;
          state  <= ST_INIT_SETUP;
        end
      endcase
    end
  end

  assign LATCH_ADDR    = latch_addr;
  assign nBITW1        = nbitw1;
  assign BUSY          = busy;
  assign nWAIT         = !(slot_full || is_init(state));
  assign OVERRUN       = overrun;
  assign SLATCH_MIRROR = mirror;

endmodule

// File: tb/tb_syslatch_seq.sv
// tb_syslatch_seq
// Directed bench for syslatch_seq with INIT_VALUE=8'hA5, STROBE_CYCLES=2.
// A negedge monitor logs every strobe (code at fall, low width) and every
// OVERRUN pulse; table vectors and hand sequences compare against that log.
module tb_syslatch_seq;

  logic        CLK = 1'b0;
  logic        nRESET = 1'b0;
  logic [23:1] M68K_ADDR = '0;
  logic        M68K_RW = 1'b1;
  logic        nAS = 1'b1;
  logic        nLDS = 1'b1;
  logic [3:0]  LATCH_ADDR;
  logic        nBITW1;
  logic        nWAIT;
  logic        BUSY;
  logic        OVERRUN;
  logic [7:0]  SLATCH_MIRROR;

  syslatch_seq #(
    .BASE_ADDR     (24'h3A0000),
    .INIT_VALUE    (8'hA5),
    .STROBE_CYCLES (2)
  ) dut (
    .CLK           (CLK),
    .nRESET        (nRESET),
    .M68K_ADDR     (M68K_ADDR),
    .M68K_RW       (M68K_RW),
    .nAS           (nAS),
    .nLDS          (nLDS),
    .LATCH_ADDR    (LATCH_ADDR),
    .nBITW1        (nBITW1),
    .nWAIT         (nWAIT),
    .BUSY          (BUSY),
    .OVERRUN       (OVERRUN),
    .SLATCH_MIRROR (SLATCH_MIRROR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Strobe / overrun log
  logic [3:0] strobe_addr[$];
  int         strobe_width[$];
  int         overrun_seen = 0;
  logic       prev_n = 1'b1;
  int         width_run = 0;

  always @(negedge CLK) begin
    if (nBITW1 === 1'b0) begin
      if (prev_n) begin
        strobe_addr.push_back(LATCH_ADDR);
        width_run = 0;
      end
      width_run++;
    end else if (!prev_n) begin
      strobe_width.push_back(width_run);
    end
    if (OVERRUN === 1'b1) overrun_seen++;
    prev_n = (nBITW1 !== 1'b0);
  end

  typedef struct {
    logic [23:0] addr;
    logic        rw;
    logic        lds;
    int          hold;
    int          exp_count;
    logic [3:0]  exp_code;
  } vec_t;

  vec_t       vecs[8];
  logic [7:0] exp_mirror;
  logic [3:0] init_codes[8];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic bus_idle();
    nAS = 1'b1;
    nLDS = 1'b1;
    M68K_RW = 1'b1;
    M68K_ADDR = '0;
  endtask

  task automatic bus_drive(input logic [23:0] a, input logic rw, input logic lds);
    M68K_ADDR = a[23:1];
    M68K_RW = rw;
    nLDS = lds;
    nAS = 1'b0;
  endtask

  task automatic clear_log();
    strobe_addr.delete();
    strobe_width.delete();
    overrun_seen = 0;
  endtask

  function automatic logic [3:0] logged_addr(input int i);
    if (i < strobe_addr.size()) return strobe_addr[i];
    return 4'hx;
  endfunction

  function automatic int logged_width(input int i);
    if (i < strobe_width.size()) return strobe_width[i];
    return -1;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_nbitw1"}, 32'(nBITW1), 32'h1);
    check({tag, "_latch_addr"}, 32'(LATCH_ADDR), 32'h0);
    check({tag, "_nwait"}, 32'(nWAIT), 32'h0);
    check({tag, "_busy"}, 32'(BUSY), 32'h1);
    check({tag, "_overrun"}, 32'(OVERRUN), 32'h0);
    check({tag, "_mirror"}, 32'(SLATCH_MIRROR), 32'h0);
  endtask

  // Releases reset and follows the 32-cycle init walk.
  task automatic release_and_check_init(input string tag);
    clear_log();
    nRESET = 1'b1;
    for (int k = 0; k < 32; k++) begin
      check({tag, "_nwait_low"}, 32'(nWAIT), 32'h0);
      tick();
    end
    check({tag, "_mirror"}, 32'(SLATCH_MIRROR), 32'hA5);
    check({tag, "_nwait_high"}, 32'(nWAIT), 32'h1);
    check({tag, "_busy"}, 32'(BUSY), 32'h0);
    check({tag, "_count"}, 32'(strobe_addr.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check({tag, "_code"}, 32'(logged_addr(i)), 32'(init_codes[i]));
      check({tag, "_width"}, 32'(logged_width(i)), 32'd2);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    init_codes = '{4'h8, 4'h1, 4'hA, 4'h3, 4'h4, 4'hD, 4'h6, 4'hF};
    //            addr          rw    lds   hold cnt code
    vecs[0] = '{24'h3A0001, 1'b0, 1'b0, 1,  1, 4'h0};
    vecs[1] = '{24'h3A001B, 1'b0, 1'b0, 10, 1, 4'hD};
    vecs[2] = '{24'h3A001B, 1'b1, 1'b0, 3,  0, 4'h0};
    vecs[3] = '{24'h3A0021, 1'b0, 1'b0, 1,  0, 4'h0};
    vecs[4] = '{24'h3A0003, 1'b0, 1'b1, 2,  0, 4'h0};
    vecs[5] = '{24'h3A000F, 1'b0, 1'b0, 1,  1, 4'h7};
    vecs[6] = '{24'h3A001D, 1'b0, 1'b0, 2,  1, 4'hE};
    vecs[7] = '{24'h3B0003, 1'b0, 1'b0, 1,  0, 4'h0};

    bus_idle();
    nRESET = 1'b0;
    repeat (3) tick();
    check_reset_state("reset");
    release_and_check_init("init");
    exp_mirror = 8'hA5;

    // Table-driven single writes
    for (int v = 0; v < 8; v++) begin
      clear_log();
      bus_drive(vecs[v].addr, vecs[v].rw, vecs[v].lds);
      repeat (vecs[v].hold) tick();
      bus_idle();
      repeat (12) tick();
      check($sformatf("vec%0d_count", v), 32'(strobe_addr.size()), 32'(vecs[v].exp_count));
      if (vecs[v].exp_count == 1) begin
        check($sformatf("vec%0d_code", v), 32'(logged_addr(0)), 32'(vecs[v].exp_code));
        exp_mirror[vecs[v].exp_code[2:0]] = vecs[v].exp_code[3];
      end
      check($sformatf("vec%0d_mirror", v), 32'(SLATCH_MIRROR), 32'(exp_mirror));
    end

    // Latency from IDLE: request registered, then SETUP, then strobe
    clear_log();
    bus_drive(24'h3A0011, 1'b0, 1'b0);
    tick();
    bus_idle();
    tick();
    check("lat_setup_nbitw1", 32'(nBITW1), 32'h1);
    check("lat_setup_code", 32'(LATCH_ADDR), 32'h8);
    check("lat_setup_busy", 32'(BUSY), 32'h1);
    tick();
    check("lat_strobe1", 32'(nBITW1), 32'h0);
    tick();
    check("lat_strobe2", 32'(nBITW1), 32'h0);
    check("lat_strobe_code", 32'(LATCH_ADDR), 32'h8);
    tick();
    check("lat_hold", 32'(nBITW1), 32'h1);
    tick();
    check("lat_mirror", 32'(SLATCH_MIRROR), 32'h65);
    check("lat_idle", 32'(BUSY), 32'h0);

    // Three writes while busy: second queued, third dropped
    repeat (3) tick();
    clear_log();
    bus_drive(24'h3A0003, 1'b0, 1'b0);
    tick();
    bus_idle();
    tick();
    bus_drive(24'h3A0005, 1'b0, 1'b0);
    tick();
    bus_idle();
    tick();
    check("ovr_queued_nwait", 32'(nWAIT), 32'h0);
    bus_drive(24'h3A0007, 1'b0, 1'b0);
    tick();
    bus_idle();
    tick();
    check("ovr_pulse", 32'(OVERRUN), 32'h1);
    tick();
    check("ovr_pulse_end", 32'(OVERRUN), 32'h0);
    repeat (15) tick();
    check("ovr_count", 32'(strobe_addr.size()), 32'd2);
    check("ovr_code0", 32'(logged_addr(0)), 32'h1);
    check("ovr_code1", 32'(logged_addr(1)), 32'h2);
    check("ovr_pulses", 32'(overrun_seen), 32'd1);
    check("ovr_mirror", 32'(SLATCH_MIRROR), 32'h61);
    check("ovr_nwait_after", 32'(nWAIT), 32'h1);

    // Slot full and new request in the same IDLE cycle
    clear_log();
    bus_drive(24'h3A0009, 1'b0, 1'b0);
    tick();
    bus_idle();
    tick();
    bus_drive(24'h3A0019, 1'b0, 1'b0);
    tick();
    bus_idle();
    tick();
    tick();
    bus_drive(24'h3A0017, 1'b0, 1'b0);
    tick();
    bus_idle();
    tick();
    check("same_slot_first", 32'(LATCH_ADDR), 32'hC);
    check("same_refill_nwait", 32'(nWAIT), 32'h0);
    repeat (20) tick();
    check("same_count", 32'(strobe_addr.size()), 32'd3);
    check("same_code0", 32'(logged_addr(0)), 32'h4);
    check("same_code1", 32'(logged_addr(1)), 32'hC);
    check("same_code2", 32'(logged_addr(2)), 32'hB);
    check("same_no_overrun", 32'(overrun_seen), 32'd0);
    check("same_mirror", 32'(SLATCH_MIRROR), 32'h79);

    // Reset in the middle of a strobe
    bus_drive(24'h3A000B, 1'b0, 1'b0);
    tick();
    bus_idle();
    tick();
    tick();
    check("mid_strobe_low", 32'(nBITW1), 32'h0);
    nRESET = 1'b0;
    tick();
    check_reset_state("midrst");
    tick();
    tick();
    release_and_check_init("reinit");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
